// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int unsigned SERIAL_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/FS.sv
// Single-bit full-subtractor cell: Dif = x - y - Bin, Bout set when the bit underflows.
module FS (
    input  logic x,
    input  logic y,
    input  logic Bin,
    output logic Dif,
    output logic Bout
);

    assign Dif  = x ^ y ^ Bin;
    assign Bout = (~x & y) | (~x & Bin) | (y & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one FS cell resolves a - b - bin LSB first over W cycles,
// result and final borrow held on a valid/ready output until taken.
module serial_sub_ctrl
    import serial_arith_pkg::*;
#(
    parameter int unsigned W = SERIAL_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         busy
);

    localparam int unsigned CW = $clog2(W);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   diff_sh;
    logic [W-1:0]   diff_sh_nx;
    logic           borrow_r;
    logic           fs_dif;
    logic           fs_bout;
    logic           accept;
    logic           shift_en;
    logic           last_bit;

    FS u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .Bin  (borrow_r),
        .Dif  (fs_dif),
        .Bout (fs_bout)
    );

    assign last_bit   = (cnt == CW'(W - 1));
    // Newly resolved bit enters at the MSB; after W shifts bit 0 sits at the LSB.
    assign diff_sh_nx = W'({fs_dif, diff_sh} >> 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = SHIFT;
            SHIFT:   if (last_bit)  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs and datapath enables
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                busy     = 1'b0;
                accept   = in_valid & ~rst;
            end
            SHIFT:   shift_en  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Shift registers, borrow, bit counter and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            borrow_r <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            a_sh     <= a;
            b_sh     <= b;
            borrow_r <= bin;
        end else if (shift_en) begin
            a_sh     <= {1'b0, a_sh[W-1:1]};
            b_sh     <= {1'b0, b_sh[W-1:1]};
            diff_sh  <= diff_sh_nx;
            borrow_r <= fs_bout;
            if (last_bit) begin
                diff <= diff_sh_nx;
                bout <= fs_bout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at W=8 and W=16 against an integer-arithmetic model.
module tb_serial_sub_ctrl;

    localparam int W8  = 8;
    localparam int W16 = 16;

    logic        clk;
    logic        rst;

    logic        in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, busy8;
    logic [7:0]  a8, b8, diff8;
    logic        in_valid16, in_ready16, bin16, out_valid16, out_ready16, bout16, busy16;
    logic [15:0] a16, b16, diff16;

    logic [16:0] got8, got16, last_got8;
    logic [16:0] exp8[$];
    logic [16:0] exp16[$];
    longint      lat8[$];
    longint      lat16[$];
    longint      cyc;
    longint      t8, t16;
    bit          rnd_mode;
    logic        prev_ov8, prev_ov16;
    int          nchk, npass;

    logic [7:0]  da [4] = '{8'h5A, 8'h00, 8'hFF, 8'h80};
    logic [7:0]  db [4] = '{8'h3C, 8'h01, 8'hFF, 8'h7F};
    logic        dbin [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [16:0] dexp [4] = '{17'h0001E, 17'h100FF, 17'h100FF, 17'h00000};

    serial_sub_ctrl #(.W(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8), .busy(busy8)
    );

    serial_sub_ctrl #(.W(W16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .bin(bin16), .out_valid(out_valid16), .out_ready(out_ready16),
        .diff(diff16), .bout(bout16), .busy(busy16)
    );

    assign got8  = {bout8, 8'h00, diff8};
    assign got16 = {bout16, diff16};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // Reference: plain signed arithmetic, borrow when the true result is negative.
    function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
        longint d;
        logic [16:0] r;
        d = longint'(a) - longint'(b) - longint'(bin);
        r = '0;
        r[16] = (d < 0);
        if (d < 0) d = d + (longint'(1) << w);
        r[15:0] = 16'(d);
        return r;
    endfunction

    task automatic drive(input int which, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, output longint acc);
        bit ok;
        acc = 0;
        ok  = 0;
        @(negedge clk);
        if (which == W8) begin
            a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; in_valid8 = 1'b1;
        end else begin
            a16 = a; b16 = b; bin16 = bin; in_valid16 = 1'b1;
        end
        for (int n = 0; n < 300; n++) begin
            if ((which == W8 && in_ready8) || (which == W16 && in_ready16)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (which == W8) begin
                exp8.push_back(model(W8, {8'h00, a[7:0]}, {8'h00, b[7:0]}, bin));
                lat8.push_back(cyc);
                in_valid8 = 1'b0;
            end else begin
                exp16.push_back(model(W16, a, b, bin));
                lat16.push_back(cyc);
                in_valid16 = 1'b0;
            end
        end else begin
            check(0, "accept_timeout", 32'(which), 32'd1);
            in_valid8  = 1'b0;
            in_valid16 = 1'b0;
        end
    endtask

    task automatic wait_drain(input int which);
        bit ok;
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (which == W8 && exp8.size() == 0 && !busy8) begin ok = 1; break; end
            if (which == W16 && exp16.size() == 0 && !busy16) begin ok = 1; break; end
        end
        if (!ok) check(0, "drain_timeout", 32'(which), 32'd0);
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (!rst) begin
            if (busy8) check(!in_ready8, "in_ready_busy8", 32'(in_ready8), 32'd0);
            if (out_valid8 && !prev_ov8) begin
                if (lat8.size() == 0) check(0, "latency8_unexpected", 32'(cyc), 32'd0);
                else begin
                    t8 = lat8.pop_front();
                    check(cyc - t8 == longint'(W8), "latency8", 32'(cyc - t8), 32'(W8));
                end
            end
            if (out_valid8) begin
                if (exp8.size() == 0) check(0, "spurious8", 32'(got8), 32'd0);
                else begin
                    check(got8 == exp8[0], out_ready8 ? "result8" : "hold8", 32'(got8), 32'(exp8[0]));
                    if (out_ready8) begin
                        last_got8 = got8;
                        exp8.delete(0);
                    end
                end
            end
        end
        prev_ov8 = rst ? 1'b0 : out_valid8;
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (!rst) begin
            if (busy16) check(!in_ready16, "in_ready_busy16", 32'(in_ready16), 32'd0);
            if (out_valid16 && !prev_ov16) begin
                if (lat16.size() == 0) check(0, "latency16_unexpected", 32'(cyc), 32'd0);
                else begin
                    t16 = lat16.pop_front();
                    check(cyc - t16 == longint'(W16), "latency16", 32'(cyc - t16), 32'(W16));
                end
            end
            if (out_valid16) begin
                if (exp16.size() == 0) check(0, "spurious16", 32'(got16), 32'd0);
                else begin
                    check(got16 == exp16[0], out_ready16 ? "result16" : "hold16", 32'(got16), 32'(exp16[0]));
                    if (out_ready16) exp16.delete(0);
                end
            end
        end
        prev_ov16 = rst ? 1'b0 : out_valid16;
    end

    // Random consumer stalls, changed away from both clock edges
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_mode) begin
                out_ready8  = ($urandom_range(0, 3) != 0);
                out_ready16 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        longint acc, prev_acc;
        nchk = 0; npass = 0; rnd_mode = 0;
        prev_ov8 = 0; prev_ov16 = 0; last_got8 = '0;
        rst = 1'b1;
        in_valid8 = 0; a8 = '0; b8 = '0; bin8 = 0; out_ready8 = 1;
        in_valid16 = 0; a16 = '0; b16 = '0; bin16 = 0; out_ready16 = 1;

        repeat (3) @(negedge clk);
        check(!in_ready8, "rst_in_ready", 32'(in_ready8), 32'd0);
        check(!out_valid8, "rst_out_valid", 32'(out_valid8), 32'd0);
        check(!busy8, "rst_busy", 32'(busy8), 32'd0);
        check(diff8 == 8'h00 && !bout8, "rst_result", 32'(got8), 32'd0);
        check(!in_ready16 && !out_valid16 && diff16 == 16'h0, "rst_16", 32'(got16), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check(in_ready8, "in_ready_after_rst", 32'(in_ready8), 32'd1);

        // Directed vectors with hand-computed results
        for (int i = 0; i < 4; i++) begin
            drive(W8, {8'h00, da[i]}, {8'h00, db[i]}, dbin[i], acc);
            wait_drain(W8);
            check(last_got8 == dexp[i], "directed", 32'(last_got8), 32'(dexp[i]));
        end

        // Backpressure in DONE: 0xC3 - 0x5D - 1 = 0x65
        out_ready8 = 0;
        drive(W8, 16'h00C3, 16'h005D, 1'b1, acc);
        for (int n = 0; n < 40 && !out_valid8; n++) @(negedge clk);
        check(out_valid8, "bp_reach_done", 32'(out_valid8), 32'd1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            in_valid8 = ~in_valid8;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            check(diff8 == 8'h65 && !bout8, "bp_hold", 32'(got8), 32'h65);
            check(!in_ready8 && out_valid8, "bp_no_accept", 32'({in_ready8, out_valid8}), 32'h1);
        end
        #1;
        in_valid8 = 0;
        out_ready8 = 1;
        @(negedge clk);
        @(negedge clk);
        check(in_ready8 && !out_valid8, "bp_release", 32'({in_ready8, out_valid8}), 32'h2);

        // Reset while cnt = 3 discards the operation
        drive(W8, 16'h0033, 16'h0011, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp8.delete();
        lat8.delete();
        @(negedge clk);
        check(!out_valid8 && !busy8, "midrst_idle", 32'({out_valid8, busy8}), 32'd0);
        check(diff8 == 8'h00, "midrst_diff", 32'(diff8), 32'd0);
        check(in_ready8, "midrst_in_ready", 32'(in_ready8), 32'd1);
        drive(W8, 16'h0010, 16'h0001, 1'b0, acc);
        wait_drain(W8);
        check(last_got8 == 17'h0000F, "after_rst_op", 32'(last_got8), 32'h0F);

        // Back-to-back with the consumer always ready
        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(W8, 16'($urandom), 16'($urandom), 1'($urandom), acc);
            if (i > 0) check(acc - prev_acc == longint'(W8 + 2), "b2b_interval", 32'(acc - prev_acc), 32'(W8 + 2));
            prev_acc = acc;
        end
        wait_drain(W8);

        // Random traffic on both widths with consumer stalls
        rnd_mode = 1;
        fork
            begin
                longint acc_a;
                for (int i = 0; i < 1000; i++) drive(W8, 16'($urandom), 16'($urandom), 1'($urandom), acc_a);
            end
            begin
                longint acc_b;
                for (int i = 0; i < 1000; i++) drive(W16, 16'($urandom), 16'($urandom), 1'($urandom), acc_b);
            end
        join
        wait_drain(W8);
        wait_drain(W16);
        rnd_mode = 0;
        #3;
        out_ready8 = 1;
        out_ready16 = 1;

        check(exp8.size() == 0, "leftover8", 32'(exp8.size()), 32'd0);
        check(exp16.size() == 0, "leftover16", 32'(exp16.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
